// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 32-bit 1-to-4 demultiplexer.
// Channel index k (0..3) maps to the out(k+1)/count(k+1) ports.
package demux_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  typedef logic [SEL_W-1:0] ch_idx_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_channel_slot.sv
// One output channel: single-entry holding register, valid flag, and delivered-word counter.
//
//   state      | meaning
//   SLOT_EMPTY | no word held; data keeps its last value
//   SLOT_FULL  | word held and offered to the consumer
module demux_channel_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic             free,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  slot_state_t state, state_nxt;
  logic        deliver;

  always_comb begin
    deliver   = (state == SLOT_FULL) && ready;
    free      = (state == SLOT_EMPTY) || ready;
    state_nxt = state;
    case (state)
      SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (deliver && !load) state_nxt = SLOT_EMPTY;
      default:    state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SLOT_EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)     data <= '0;
    else if (load) data <= load_data;
  end

  // Counter counts the outgoing word even when a new word replaces it on the same edge.
  always_ff @(posedge clk) begin
    if (reset)        count <= '0;
    else if (deliver) count <= count + 1'b1;
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux32_1to4_reg.sv
// Registered 1-to-4 demultiplexer: steers each accepted word into the selected
// channel's holding register; each channel drains independently to its consumer.
module demux32_1to4_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_select,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic [WIDTH-1:0]  out4,
  output logic [CNT_W-1:0]  count1,
  output logic [CNT_W-1:0]  count2,
  output logic [CNT_W-1:0]  count3,
  output logic [CNT_W-1:0]  count4,
  output logic              busy
);

  logic [NUM_CH-1:0] ch_free;
  logic [NUM_CH-1:0] ch_load;
  logic [WIDTH-1:0]  ch_data  [NUM_CH];
  logic [CNT_W-1:0]  ch_count [NUM_CH];
  logic              accept;

  // in_ready depends only on select and channel status, never on in_data.
  assign in_ready = !reset && ch_free[in_select];
  assign accept   = in_valid && in_ready;

  always_comb begin
    ch_load = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_load[k] = accept && (in_select == ch_idx_t'(k));
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_channel_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (ch_load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .free      (ch_free[k]),
      .data      (ch_data[k]),
      .count     (ch_count[k])
    );
  end

  assign out1   = ch_data[0];
  assign out2   = ch_data[1];
  assign out3   = ch_data[2];
  assign out4   = ch_data[3];
  assign count1 = ch_count[0];
  assign count2 = ch_count[1];
  assign count3 = ch_count[2];
  assign count4 = ch_count[3];
  assign busy   = |out_valid;

endmodule
